// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and constants for the or1420 register-file write-back scheduler.
package rf_wb_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {SRC_NONE, SRC_EX, SRC_LD, SRC_CI} src_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Core-side bundle of the write-back scheduler: producers, issue, decode reads, rf write port.
interface regfile_wb_scheduler_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              stall;
  logic              exWe;
  logic [ADDR_W-1:0] exAddr;
  logic [DATA_W-1:0] exData;
  logic              ldValid;
  logic [ADDR_W-1:0] ldAddr;
  logic [DATA_W-1:0] ldData;
  logic              ldReady;
  logic              ciValid;
  logic [ADDR_W-1:0] ciAddr;
  logic [DATA_W-1:0] ciData;
  logic              ciReady;
  logic              issueValid;
  logic [ADDR_W-1:0] issueAddr;
  logic [ADDR_W-1:0] readAddrA;
  logic [ADDR_W-1:0] readAddrB;
  logic              hazardA;
  logic              hazardB;
  logic              rfWe;
  logic [ADDR_W-1:0] rfAddr;
  logic [DATA_W-1:0] rfData;

  modport slave (
    input  stall, exWe, exAddr, exData, ldValid, ldAddr, ldData,
           ciValid, ciAddr, ciData, issueValid, issueAddr, readAddrA, readAddrB,
    output ldReady, ciReady, hazardA, hazardB, rfWe, rfAddr, rfData
  );

  modport master (
    output stall, exWe, exAddr, exData, ldValid, ldAddr, ldData,
           ciValid, ciAddr, ciData, issueValid, issueAddr, readAddrA, readAddrB,
    input  ldReady, ciReady, hazardA, hazardB, rfWe, rfAddr, rfData
  );
endinterface

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Pending-destination vector for loads/custom instructions plus the two decode hazard lookups.
module rf_wb_scoreboard
  import rf_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              hazard_a,
  output logic              hazard_b
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [NREG-1:0] pending, pending_nxt;

  // Set is applied after clear: a same-cycle re-issue means a newer producer is in flight.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_addr] = 1'b0;
    if (set_en && set_addr != ZERO) pending_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign hazard_a = (rd_addr_a != ZERO) && (pending[rd_addr_a] || (wb_we && wb_addr == rd_addr_a));
  assign hazard_b = (rd_addr_b != ZERO) && (pending[rd_addr_b] || (wb_we && wb_addr == rd_addr_b));
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port arbiter (ex > round-robin ld/ci) with one registered write stage.
// RF_WB_SCOREBOARD_EN builds the pending-destination scoreboard and hazard outputs.
module regfile_wb_scheduler
  import rf_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic cpuClock,
  input logic nReset,
  regfile_wb_scheduler_if.slave bus
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  src_e              grant, wb_src;
  logic              ptr_ci;  // 0: ld preferred on a tie, 1: ci preferred
  logic [ADDR_W-1:0] g_addr, addr_q;
  logic [DATA_W-1:0] g_data, data_q;
  logic              we_q, commit, clr_en;

  always_comb begin
    grant = SRC_NONE;
    if (!bus.stall) begin
      if (bus.exWe)                                     grant = SRC_EX;
      else if (bus.ldValid && (!bus.ciValid || !ptr_ci)) grant = SRC_LD;
      else if (bus.ciValid)                             grant = SRC_CI;
    end
  end

  always_comb begin
    g_addr = bus.exAddr;
    g_data = bus.exData;
    case (grant)
      SRC_LD:  begin g_addr = bus.ldAddr; g_data = bus.ldData; end
      SRC_CI:  begin g_addr = bus.ciAddr; g_data = bus.ciData; end
      default: ;
    endcase
  end

  assign bus.ldReady = (grant == SRC_LD);
  assign bus.ciReady = (grant == SRC_CI);

  // Stall freezes the whole stage; an ex request seen under stall is re-presented later.
  always_ff @(posedge cpuClock or negedge nReset) begin
    if (!nReset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      wb_src <= SRC_NONE;
      ptr_ci <= 1'b0;
    end else if (!bus.stall) begin
      we_q   <= (grant != SRC_NONE) && (g_addr != ZERO);
      wb_src <= grant;
      if (grant != SRC_NONE) begin
        addr_q <= g_addr;
        data_q <= g_data;
      end
      if (grant == SRC_LD)      ptr_ci <= 1'b1;
      else if (grant == SRC_CI) ptr_ci <= 1'b0;
    end
  end

  assign bus.rfWe   = we_q;
  assign bus.rfAddr = addr_q;
  assign bus.rfData = data_q;

  assign commit = we_q && !bus.stall;
  assign clr_en = commit && (wb_src == SRC_LD || wb_src == SRC_CI);

`ifdef RF_WB_SCOREBOARD_EN
  rf_wb_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (cpuClock),
    .rst_n    (nReset),
    .set_en   (bus.issueValid),
    .set_addr (bus.issueAddr),
    .clr_en   (clr_en),
    .clr_addr (addr_q),
    .rd_addr_a(bus.readAddrA),
    .rd_addr_b(bus.readAddrB),
    .wb_we    (we_q),
    .wb_addr  (addr_q),
    .hazard_a (bus.hazardA),
    .hazard_b (bus.hazardB)
  );
`else
  // Without the scoreboard the core stalls on every ld/ci, so no hazard is ever reported.
  assign bus.hazardA = 1'b0;
  assign bus.hazardB = 1'b0;
  logic unused;
  assign unused = &{1'b0, bus.issueValid, bus.issueAddr, bus.readAddrA, bus.readAddrB, clr_en};
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized scoreboard bench for regfile_wb_scheduler against a queue-based write model.
module tb_regfile_wb_scheduler;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic cpuClock = 1'b0;
  logic nReset   = 1'b0;
  always #5 cpuClock = ~cpuClock;

  regfile_wb_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) b ();
  regfile_wb_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (.cpuClock(cpuClock), .nReset(nReset), .bus(b));

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            lc;   // load/custom-instruction sourced
  } wr_t;

  wr_t q[$];              // writes granted but not yet committed
  bit  m_pend[32];        // destinations issued but not yet written back
  bit  m_ci_next;         // round-robin: ci wins the next tie
  bit  ld_fire, ci_fire;  // transfer happened on the latest edge
  bit  run = 1'b0;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ld();
    return !b.stall && !b.exWe && b.ldValid && (!b.ciValid || !m_ci_next);
  endfunction
  function automatic bit exp_ci();
    return !b.stall && !b.exWe && b.ciValid && (!b.ldValid || m_ci_next);
  endfunction
  function automatic bit exp_hz(input logic [AW-1:0] a);
    if (!SB || a == 0) return 1'b0;
    return m_pend[a] || (q.size() != 0 && q[0].addr == a);
  endfunction

  // Reference model: committed writes leave the queue, new grants enter it.
  always @(posedge cpuClock or negedge nReset) begin
    if (!nReset) begin
      q.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ci_next = 1'b0;
      ld_fire = 1'b0;
      ci_fire = 1'b0;
    end else begin
      ld_fire = exp_ld();
      ci_fire = exp_ci();
      if (!b.stall && q.size() != 0) begin
        if (q[0].lc) m_pend[q[0].addr] = 1'b0;
        void'(q.pop_front());
      end
      if (b.issueValid && b.issueAddr != 0) m_pend[b.issueAddr] = 1'b1;
      if (!b.stall && b.exWe) begin
        if (b.exAddr != 0) q.push_back('{b.exAddr, b.exData, 1'b0});
      end else if (ld_fire) begin
        if (b.ldAddr != 0) q.push_back('{b.ldAddr, b.ldData, 1'b1});
        m_ci_next = 1'b1;
      end else if (ci_fire) begin
        if (b.ciAddr != 0) q.push_back('{b.ciAddr, b.ciData, 1'b1});
        m_ci_next = 1'b0;
      end
    end
  end

  // Monitor: compares everything the DUT presents against the model each cycle.
  always @(negedge cpuClock) begin
    if (run && nReset) begin
      chk("ldReady", 32'(b.ldReady), 32'(exp_ld()));
      chk("ciReady", 32'(b.ciReady), 32'(exp_ci()));
      chk("hazardA", 32'(b.hazardA), 32'(exp_hz(b.readAddrA)));
      chk("hazardB", 32'(b.hazardB), 32'(exp_hz(b.readAddrB)));
      chk("rfWe", 32'(b.rfWe), 32'(q.size() != 0));
      if (b.rfWe && q.size() != 0) begin
        chk("rfAddr", 32'(b.rfAddr), 32'(q[0].addr));
        chk("rfData", b.rfData, q[0].data);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge cpuClock);
      #1;
    end
  endtask

  task automatic idle();
    b.stall = 0; b.exWe = 0; b.exAddr = 0; b.exData = 0;
    b.ldValid = 0; b.ldAddr = 0; b.ldData = 0;
    b.ciValid = 0; b.ciAddr = 0; b.ciData = 0;
    b.issueValid = 0; b.issueAddr = 0; b.readAddrA = 0; b.readAddrB = 0;
  endtask

  task automatic rnd_cycle();
    if (!b.ldValid || ld_fire) begin
      b.ldValid = ($urandom_range(0, 2) != 0);
      b.ldAddr  = AW'($urandom_range(0, 7));
      b.ldData  = $urandom;
    end
    if (!b.ciValid || ci_fire) begin
      b.ciValid = ($urandom_range(0, 2) != 0);
      b.ciAddr  = AW'($urandom_range(0, 7));
      b.ciData  = $urandom;
    end
    b.exWe       = ($urandom_range(0, 3) == 0);
    b.exAddr     = AW'($urandom_range(0, 7));
    b.exData     = $urandom;
    b.stall      = ($urandom_range(0, 4) == 0);
    b.issueValid = ($urandom_range(0, 2) == 0);
    b.issueAddr  = AW'($urandom_range(0, 7));
    b.readAddrA  = AW'($urandom_range(0, 7));
    b.readAddrB  = AW'($urandom_range(0, 7));
    if ($urandom_range(0, 199) == 0) begin
      nReset = 1'b0;
      #2 nReset = 1'b1;
    end
  endtask

  initial begin
    idle();
    #12 nReset = 1'b1;
    #1;
    chk("reset_rfWe", 32'(b.rfWe), 0);
    chk("reset_rfAddr", 32'(b.rfAddr), 0);
    chk("reset_rfData", b.rfData, 0);
    run = 1'b1;
    step();

    // Execute write lands one cycle after the grant.
    b.exWe = 1; b.exAddr = 3; b.exData = 32'hDEADBEEF;
    step();
    b.exWe = 0;
    chk("ex_rfAddr", 32'(b.rfAddr), 3);
    chk("ex_rfData", b.rfData, 32'hDEADBEEF);
    step();

    // Tie between ld and ci alternates, ld first.
    b.ldValid = 1; b.ldAddr = 1; b.ldData = 32'h11;
    b.ciValid = 1; b.ciAddr = 2; b.ciData = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #3 chk("alt_ldReady", 32'(b.ldReady), 32'(i % 2 == 0));
      step();
    end
    idle();
    step();

    // Execute blocks a load for one cycle.
    b.exWe = 1; b.exAddr = 4; b.ldValid = 1; b.ldAddr = 6; b.ldData = 32'h66;
    #3 chk("ex_blocks_ld", 32'(b.ldReady), 0);
    step();
    b.exWe = 0;
    #3 chk("ld_after_ex", 32'(b.ldReady), 1);
    step();
    b.ldValid = 0;
    chk("ld_lands", b.rfData, 32'h66);
    step();

    // Hazard raised by issue and dropped after the load commits.
    b.issueValid = 1; b.issueAddr = 7; b.readAddrA = 7;
    step();
    b.issueValid = 0;
    chk("hz_set", 32'(b.hazardA), 32'(SB));
    b.ldValid = 1; b.ldAddr = 7; b.ldData = 32'h77;
    step();
    b.ldValid = 0;
    step();
    chk("hz_clear", 32'(b.hazardA), 0);

    // Stall holds the write stage.
    b.ciValid = 1; b.ciAddr = 9; b.ciData = 32'h99;
    step();
    b.ciValid = 0; b.stall = 1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", b.rfData, 32'h99);
      step();
    end
    b.stall = 0;
    step(2);

    // r0 destination is accepted but never written.
    b.ldValid = 1; b.ldAddr = 0; b.ldData = 32'h5A5A;
    #3 chk("r0_ready", 32'(b.ldReady), 1);
    step();
    b.ldValid = 0;
    chk("r0_no_we", 32'(b.rfWe), 0);

    // Reset mid-stall clears everything without an edge.
    b.issueValid = 1; b.issueAddr = 5; b.exWe = 1; b.exAddr = 5; b.exData = 32'h55;
    step();
    b.issueValid = 0; b.exWe = 0; b.stall = 1; b.readAddrA = 5;
    #2 nReset = 1'b0;
    #1;
    chk("rst_rfWe", 32'(b.rfWe), 0);
    chk("rst_rfAddr", 32'(b.rfAddr), 0);
    chk("rst_rfData", b.rfData, 0);
    chk("rst_hazardA", 32'(b.hazardA), 0);
    #2 nReset = 1'b1;
    idle();
    step(2);

    for (int i = 0; i < 3000; i++) begin
      rnd_cycle();
      step();
    end
    idle();
    step(2);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
